// File: rtl/run_monitor.sv
// Run-control and PC trace monitor: starts a run, counts cycles and retired
// instructions, records a circular PC trace and stops on halt PC, bad instruction or watchdog.
module run_monitor #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                TRACE_DEPTH = 8,
  parameter int                TIMEOUT     = 1024,
  parameter int                CNT_W       = 16,
  parameter logic [ADDR_W-1:0] HALT_ADDR   = '1,
  localparam int               PTR_W       = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              running,
  output logic              halted,
  output logic              done,
  output logic [1:0]        halt_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count,
  output logic [PTR_W:0]    trace_fill,
  input  logic [PTR_W-1:0]  trace_rd_idx,
  output logic [ADDR_W-1:0] trace_rd_pc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_HALTPC  = 2'b01;
  localparam logic [1:0] CODE_INVALID = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W:0]   FILL_MAX    = (PTR_W + 1)'(TRACE_DEPTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   retire_q, retire_d;
  logic [1:0]         code_q, code_d;
  logic               done_q, done_d;
  logic [PTR_W:0]     fill_q, fill_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               trace_we;
  logic               halt_hit;
  logic [1:0]         halt_sel;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]  trace_mem [TRACE_DEPTH];
  logic               unused_instr;

  // The instruction word is observed but not yet recorded in the trace.
  assign unused_instr = ^instr;

  always_comb begin
    halt_hit = 1'b1;
    halt_sel = CODE_NONE;
    if (pc == HALT_ADDR)            halt_sel = CODE_HALTPC;
    else if (!instr_valid)          halt_sel = CODE_INVALID;
    else if (cycle_q == TIMEOUT_CNT) halt_sel = CODE_TIMEOUT;
    else                            halt_hit = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    retire_d = retire_q;
    code_d   = code_q;
    done_d   = 1'b0;
    fill_d   = fill_q;
    wr_ptr_d = wr_ptr_q;
    trace_we = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d  = ST_RUN;
          cycle_d  = '0;
          retire_d = '0;
          code_d   = CODE_NONE;
          fill_d   = '0;
          wr_ptr_d = '0;
        end
      end
      ST_RUN: begin
        cycle_d = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
        if (!stall) begin
          retire_d = (retire_q == CNT_MAX) ? retire_q : retire_q + CNT_W'(1);
          trace_we = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + (PTR_W + 1)'(1);
        end
        // Halt checks also apply on stalled cycles; the halting cycle is still counted.
        if (halt_hit) begin
          state_d = ST_HALT;
          code_d  = halt_sel;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cycle_q  <= '0;
      retire_q <= '0;
      code_q   <= CODE_NONE;
      done_q   <= 1'b0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      code_q   <= code_d;
      done_q   <= done_d;
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is never reset; stale entries are hidden by the fill count.
  always_ff @(posedge clk) begin
    if (trace_we && !rst) trace_mem[wr_ptr_q] <= pc;
  end

  assign rd_ptr      = wr_ptr_q - PTR_W'(1) - trace_rd_idx;
  assign trace_rd_pc = ({1'b0, trace_rd_idx} < fill_q) ? trace_mem[rd_ptr] : '0;

  assign running      = (state_q == ST_RUN);
  assign halted       = (state_q == ST_HALT);
  assign done         = done_q;
  assign halt_code    = code_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign trace_fill   = fill_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor with depth-4 trace, 16-cycle watchdog and halt PC 8'hFF.
module tb_run_monitor;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              running;
  logic              halted;
  logic              done;
  logic [1:0]        halt_code;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  retire_count;
  logic [2:0]        trace_fill;
  logic [1:0]        trace_rd_idx;
  logic [ADDR_W-1:0] trace_rd_pc;

  int tests_run;
  int tests_failed;
  logic [ADDR_W-1:0] exp_q[$];

  run_monitor #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TRACE_DEPTH(DEPTH),
    .TIMEOUT(16), .CNT_W(CNT_W), .HALT_ADDR(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .running(running),
    .halted(halted), .done(done), .halt_code(halt_code),
    .cycle_count(cycle_count), .retire_count(retire_count),
    .trace_fill(trace_fill), .trace_rd_idx(trace_rd_idx),
    .trace_rd_pc(trace_rd_pc)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one edge's inputs, then sample outputs 1ns after that edge
  task automatic tick(input logic s, input logic [ADDR_W-1:0] p, input logic v);
    stall       = s;
    pc          = p;
    instr_valid = v;
    instr       = DATA_W'($urandom_range(0, 255));
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic run_e, input logic halt_e,
                              input logic done_e, input logic [1:0] code_e,
                              input int cyc_e, input int ret_e, input int fill_e);
    check({tag, ".running"}, running, run_e);
    check({tag, ".halted"}, halted, halt_e);
    check({tag, ".done"}, done, done_e);
    check({tag, ".code"}, halt_code, code_e);
    check({tag, ".cycles"}, cycle_count, cyc_e);
    check({tag, ".retired"}, retire_count, ret_e);
    check({tag, ".fill"}, trace_fill, fill_e);
  endtask

  // scoreboard: exp_q holds expected trace reads for idx 0..DEPTH-1
  task automatic check_trace(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      trace_rd_idx = 2'(i);
      #1;
      check($sformatf("%s.trace%0d", tag, i), trace_rd_pc, exp_q.pop_front());
    end
    trace_rd_idx = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; start = 1'b0; stall = 1'b0; pc = '0; instr = '0;
    instr_valid = 1'b1; trace_rd_idx = '0;

    // scenario 1: normal run ending on halt PC
    tick(0, 8'h00, 1);
    rst = 1'b0;
    check_status("reset", 0, 0, 0, 2'b00, 0, 0, 0);
    check("reset.rd_pc", trace_rd_pc, 0);
    start = 1'b1;
    tick(0, 8'h00, 1);
    start = 1'b0;
    check_status("s1.start", 1, 0, 0, 2'b00, 0, 0, 0);
    tick(0, 8'h00, 1);
    tick(0, 8'h01, 1);
    tick(0, 8'h02, 1);
    tick(0, 8'h03, 1);
    check_status("s1.mid", 1, 0, 0, 2'b00, 4, 4, 4);
    tick(0, 8'hFF, 1);
    check_status("s1.halt", 0, 1, 1, 2'b01, 5, 5, 4);
    exp_q = '{8'hFF, 8'h03, 8'h02, 8'h01};
    check_trace("s1");
    tick(0, 8'h10, 1);
    check_status("s1.hold", 0, 1, 0, 2'b01, 5, 5, 4);

    // scenario 6 + 2: restart from HALT with start held into RUN, then invalid instr
    start = 1'b1;
    tick(0, 8'h20, 1);
    check_status("s6.restart", 1, 0, 0, 2'b00, 0, 0, 0);
    tick(0, 8'h00, 1);
    check_status("s6.start_in_run", 1, 0, 0, 2'b00, 1, 1, 1);
    tick(0, 8'h01, 1);
    start = 1'b0;
    check_status("s6.start_in_run2", 1, 0, 0, 2'b00, 2, 2, 2);
    tick(0, 8'h02, 0);
    check_status("s2.halt", 0, 1, 1, 2'b10, 3, 3, 3);
    exp_q = '{8'h02, 8'h01, 8'h00, 8'h00};
    check_trace("s2");

    // scenario 3: watchdog on the 16th RUN cycle
    start = 1'b1;
    tick(0, 8'h05, 1);
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick(0, 8'h05, 1);
    check_status("s3.cycle15", 1, 0, 0, 2'b00, 15, 15, 4);
    tick(0, 8'h05, 1);
    check_status("s3.timeout", 0, 1, 1, 2'b11, 16, 16, 4);
    exp_q = '{8'h05, 8'h05, 8'h05, 8'h05};
    check_trace("s3");

    // scenario 4: stalls suppress retire and trace writes
    start = 1'b1;
    tick(0, 8'h30, 1);
    start = 1'b0;
    tick(0, 8'h00, 1);
    tick(0, 8'h01, 1);
    tick(1, 8'h01, 1);
    tick(1, 8'h01, 1);
    check_status("s4.stalled", 1, 0, 0, 2'b00, 4, 2, 2);
    tick(0, 8'h02, 1);
    tick(0, 8'hFF, 1);
    check_status("s4.halt", 0, 1, 1, 2'b01, 6, 4, 4);
    exp_q = '{8'hFF, 8'h02, 8'h01, 8'h00};
    check_trace("s4");

    // scenario 5: reset mid-run beats a halt condition on the same edge
    start = 1'b1;
    tick(0, 8'h40, 1);
    start = 1'b0;
    tick(0, 8'h41, 1);
    tick(0, 8'h42, 1);
    rst = 1'b1;
    tick(0, 8'hFF, 1);
    check_status("s5.rst", 0, 0, 0, 2'b00, 0, 0, 0);
    check("s5.rd_pc", trace_rd_pc, 0);
    start = 1'b1;
    tick(0, 8'h00, 1);
    check_status("s5.rst_start", 0, 0, 0, 2'b00, 0, 0, 0);
    rst = 1'b0;
    start = 1'b0;
    tick(0, 8'h00, 1);
    check_status("s5.idle", 0, 0, 0, 2'b00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
Parametrised run-control and trace block for the processor simulation and debug harness. It replaces ad-hoc end-of-program checks with a state machine that starts a run and counts cycles and retired instructions. It captures a circular PC trace and stops the run on a halt address, an invalid instruction or a watchdog timeout. It sits beside the core and observes the PC and instruction buses. It never drives the core.

Parameters:
ADDR_W, 8, PC / instruction-address width
DATA_W, 8, instruction width
TRACE_DEPTH, 8, trace entries; power of 2, minimum 2
TIMEOUT, 1024, maximum RUN cycles before forced halt; minimum 1, must be less than 2**CNT_W
CNT_W, 16, cycle/retire counter width
HALT_ADDR, all ones (ADDR_W bits), PC value that ends a run

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a run (sampled when not RUN)
stall  in  1  core not advancing this cycle
pc  in  ADDR_W  current instruction address
instr  in  DATA_W  current instruction (observed only; reserved for trace extension)
instr_valid  in  1  instruction bus holds a defined value
running  out  1  state == RUN
halted  out  1  state == HALT
done  out  1  one-cycle pulse on entry to HALT
halt_code  out  2  00 none, 01 halt address, 10 invalid instr, 11 timeout
cycle_count  out  CNT_W  RUN cycles elapsed
retire_count  out  CNT_W  non-stalled RUN cycles
trace_fill  out  log2(TRACE_DEPTH)+1  valid trace entries
trace_rd_idx  in  log2(TRACE_DEPTH)  0 = most recent entry
trace_rd_pc  out  ADDR_W  trace entry at trace_rd_idx, combinational read

Behaviour:
- Reset (rst high at edge):
  - state IDLE.
  - All outputs 0: counters, halt_code, done, trace_fill, write pointer.
  - Trace storage contents are don't-care; reads are masked by trace_fill.
  - rst has priority over every other input, including start and halt conditions.
- States: IDLE, RUN, HALT.
- IDLE or HALT, start=1 at edge k:
  - state becomes RUN after edge k.
  - At the same edge: counters, halt_code, trace_fill and write pointer are cleared; done is 0.
- RUN, at each edge:
  - cycle_count increments.
  - If stall=0: retire_count increments, pc is written at the write pointer, the write pointer increments modulo TRACE_DEPTH, and trace_fill increments, saturating at TRACE_DEPTH.
  - If stall=1: no trace write and no retire increment.
  - Halt checks run on that edge's inputs every RUN cycle, including stalled cycles.
  - Halt priority, first match wins:
    - pc == HALT_ADDR gives halt_code 01.
    - instr_valid == 0 gives 10.
    - cycle_count == TIMEOUT-1 (the TIMEOUT-th cycle) gives 11.
  - The halting cycle is itself counted and, if not stalled, traced.
  - On a halt match, state becomes HALT after that edge and done=1 for exactly one cycle.
  - start is ignored in RUN.
- HALT: counters, halt_code and trace are held until start or rst.
- Counters saturate at 2**CNT_W-1; they never wrap.
- Trace read:
  - trace_rd_pc = entry (write pointer - 1 - trace_rd_idx) modulo TRACE_DEPTH.
  - trace_rd_pc returns 0 when trace_rd_idx >= trace_fill.
  - Read is valid in every state.
- Reset mid-run: after the edge, state IDLE and all outputs 0; no done pulse.

Test Plan:
Common setup: TRACE_DEPTH=4, TIMEOUT=16, HALT_ADDR=8'hFF.
1. rst, then start; pc 00,01,02,03,FF with stall=0 and instr_valid=1 -> halted=1 and done pulses once after the FF edge; halt_code=01, cycle_count=5, retire_count=5, trace_fill=4; idx0..3 = FF,03,02,01.
2. start; pc 00,01,02 with instr_valid=0 on the 3rd RUN cycle -> halt_code=10, cycle_count=3, trace idx0=02, trace_fill=3; idx3 reads 0.
3. start; pc held at 05, instr_valid=1 -> after 16 RUN cycles, halt_code=11, cycle_count=16, retire_count=16, all trace entries 05.
4. start; pc 00,01,01,01,02,FF with stall=1 on cycles 3-4 -> cycle_count=6, retire_count=4, halt_code=01; idx0..3 = FF,02,01,00.
5. rst asserted on the 3rd RUN cycle -> next cycle running=0, halted=0, counts 0, trace_fill=0, no done. rst and start asserted at the same edge -> stays IDLE.
6. From HALT (scenario 1), pulse start -> running=1 with counters, trace_fill and halt_code 0. start while RUN has no effect.
